dm9000a_tx_sequencer: RTL and testbench

// - Downstream of the packet builder. Takes an assembled frame as a 16-bit word stream and buffers one whole frame.
// - Replays the frame into the DM9000A TX SRAM over its 16-bit host bus, then programs TX length and issues the TX request.
// - Holds the bus for its whole write sequence; one frame in flight at a time.

---
 rtl/dm9000a_tx_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_dm9000a_tx_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dm9000a_tx_sequencer.sv
// dm9000a_tx_sequencer
// Buffers one complete frame that arrives as a 16-bit word stream. It then
// replays the frame into the DM9000A TX SRAM over the host bus. After the
// payload it programs the TX length registers and issues the TX request.
// Only one frame is in flight at a time.
// Optional feature: define ENET_TX_PAD_EN to pad short frames with zero words
// up to 30 words (60 bytes). In the default build the payload and the length
// reflect the received word count exactly.
// Every bus write lasts 1 + WR_PULSE + WR_GAP cycles:
//   - one set-up cycle with CS_N low,
//   - WR_PULSE cycles with WR_N low,
//   - WR_GAP cycles with CS_N high and the data still held.
// All bus outputs come straight from flops, so there is no decode glitching
// on the pins.
module dm9000a_tx_sequencer #(
    parameter int DEPTH    = 64,
    parameter int WR_PULSE = 2,
    parameter int WR_GAP   = 2,
    parameter int HOLDOFF  = 32
) (
    input  logic        CLOCK_50,
    input  logic        RST_N,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [15:0] ENET_DATA,
    output logic        ENET_CMD,
    output logic        ENET_CS_N,
    output logic        ENET_WR_N,
    output logic        ENET_RD_N,
    output logic        busy,
    output logic        tx_done,
    output logic        overflow
);

    localparam int WR_LEN    = 1 + WR_PULSE + WR_GAP;
    localparam int PAD_WORDS = 30;
`ifdef ENET_TX_PAD_EN
    localparam int MIN_WORDS = PAD_WORDS;
`else
    localparam int MIN_WORDS = 1;
`endif
    localparam int NMAX = (DEPTH > PAD_WORDS) ? DEPTH : PAD_WORDS;
    localparam int CW   = $clog2(NMAX + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PMAX = (WR_LEN > HOLDOFF) ? WR_LEN : HOLDOFF;
    localparam int PW   = $clog2(PMAX + 1);

    // Bus-writing states are consecutive so that each successor is state + 1.
    // PAYLOAD is the exception: it repeats once per word.
    localparam logic [3:0] ST_FILL      = 4'd0;
    localparam logic [3:0] ST_DROP      = 4'd1;
    localparam logic [3:0] ST_MWCMD_IDX = 4'd2;
    localparam logic [3:0] ST_PAYLOAD   = 4'd3;
    localparam logic [3:0] ST_TXPLL_IDX = 4'd4;
    localparam logic [3:0] ST_TXPLL_DAT = 4'd5;
    localparam logic [3:0] ST_TXPLH_IDX = 4'd6;
    localparam logic [3:0] ST_TXPLH_DAT = 4'd7;
    localparam logic [3:0] ST_TCR_IDX   = 4'd8;
    localparam logic [3:0] ST_TCR_DAT   = 4'd9;
    localparam logic [3:0] ST_HOLDOFF   = 4'd10;

    logic [15:0]   mem [DEPTH];
    logic [15:0]   rd_data_q;
    logic          mem_we;

    logic [3:0]    state_q,    state_d;
    logic [PW-1:0] phase_q,    phase_d;
    logic [CW-1:0] count_q,    count_d;
    logic [CW-1:0] widx_q,     widx_d;
    logic [15:0]   data_q,     data_d;
    logic          cmd_q,      cmd_d;
    logic          cs_n_q,     cs_n_d;
    logic          wr_n_q,     wr_n_d;
    logic          busy_q,     busy_d;
    logic          tx_done_q,  tx_done_d;
    logic          overflow_q, overflow_d;
    logic          rdy_q;

    logic          accept;
    logic          last_phase;
    logic [CW-1:0] ntot;
    logic [15:0]   len;

    function automatic logic is_write(input logic [3:0] s);
        return (s != ST_FILL) && (s != ST_DROP) && (s != ST_HOLDOFF);
    endfunction

    assign s_ready   = rdy_q && ((state_q == ST_FILL) || (state_q == ST_DROP));
    assign accept    = s_valid && s_ready;
    assign ntot      = (count_q < CW'(MIN_WORDS)) ? CW'(MIN_WORDS) : count_q;
    assign len       = 16'(ntot) << 1;

    assign ENET_DATA = data_q;
    assign ENET_CMD  = cmd_q;
    assign ENET_CS_N = cs_n_q;
    assign ENET_WR_N = wr_n_q;
    assign ENET_RD_N = 1'b1;
    assign busy      = busy_q;
    assign tx_done   = tx_done_q;
    assign overflow  = overflow_q;

    // Frame buffer: write at the fill pointer, registered read at the replay index.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[count_q[AW-1:0]] <= s_data;
        end
        rd_data_q <= mem[widx_q[AW-1:0]];
    end

    // Sequencer next state; outputs are decoded from the next state so the pins stay registered.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        count_d    = count_q;
        widx_d     = widx_q;
        data_d     = data_q;
        cmd_d      = cmd_q;
        overflow_d = 1'b0;
        mem_we     = 1'b0;
        last_phase = (phase_q == PW'(WR_LEN - 1));

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    mem_we = 1'b1;
                    if (s_last) begin
                        count_d = count_q + CW'(1);
                        state_d = ST_MWCMD_IDX;
                        phase_d = '0;
                        widx_d  = '0;
                    end else if (count_q == CW'(DEPTH - 1)) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DROP;
                        count_d    = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            ST_DROP: begin
                if (accept && s_last) begin
                    state_d = ST_FILL;
                    count_d = '0;
                end
            end
            ST_HOLDOFF: begin
                if (phase_q == PW'(HOLDOFF - 1)) begin
                    state_d = ST_FILL;
                    phase_d = '0;
                    count_d = '0;
                    widx_d  = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_PAYLOAD: begin
                if (last_phase) begin
                    phase_d = '0;
                    if (widx_q == ntot) begin
                        state_d = ST_TXPLL_IDX;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                if (last_phase) begin
                    phase_d = '0;
                    state_d = state_q + 4'd1;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
        endcase

        // A write starts whenever a bus state is entered at phase 0.
        // Its command and data are latched then and held for the whole write.
        if (is_write(state_d) && (phase_d == '0)) begin
            case (state_d)
                ST_MWCMD_IDX: begin cmd_d = 1'b0; data_d = 16'h00F8; end
                ST_PAYLOAD: begin
                    cmd_d  = 1'b1;
                    data_d = (widx_q < count_q) ? rd_data_q : 16'h0000;
                    widx_d = widx_q + CW'(1);
                end
                ST_TXPLL_IDX: begin cmd_d = 1'b0; data_d = 16'h00FC; end
                ST_TXPLL_DAT: begin cmd_d = 1'b1; data_d = {8'h00, len[7:0]}; end
                ST_TXPLH_IDX: begin cmd_d = 1'b0; data_d = 16'h00FD; end
                ST_TXPLH_DAT: begin cmd_d = 1'b1; data_d = {8'h00, len[15:8]}; end
                ST_TCR_IDX:   begin cmd_d = 1'b0; data_d = 16'h0002; end
                default:      begin cmd_d = 1'b1; data_d = 16'h0001; end
            endcase
        end

        cs_n_d    = !(is_write(state_d) && (phase_d <= PW'(WR_PULSE)));
        wr_n_d    = !(is_write(state_d) && (phase_d >= PW'(1)) && (phase_d <= PW'(WR_PULSE)));
        busy_d    = (state_d != ST_FILL) && (state_d != ST_DROP);
        tx_done_d = (state_d == ST_TCR_DAT) && (phase_d == PW'(WR_LEN - 1));
    end

    // State and registered outputs; reset aborts any write in progress.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state_q    <= ST_FILL;
            phase_q    <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            data_q     <= 16'h0000;
            cmd_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            overflow_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            data_q     <= data_d;
            cmd_q      <= cmd_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
            overflow_q <= overflow_d;
            rdy_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dm9000a_tx_sequencer.sv
// Directed bench for dm9000a_tx_sequencer. A bus monitor records every
// host-bus write; each frame's write list is compared against the list
// hand-derived for that frame.
module tb_dm9000a_tx_sequencer;

    localparam int WR_PULSE = 2;
    localparam int WR_GAP   = 2;
    localparam int HOLDOFF  = 32;
    localparam int WR_LEN   = 1 + WR_PULSE + WR_GAP;
`ifdef ENET_TX_PAD_EN
    localparam int MIN_WORDS = 30;
`else
    localparam int MIN_WORDS = 1;
`endif

    logic        clk = 1'b0;
    logic        RST_N;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] ENET_DATA;
    logic        ENET_CMD, ENET_CS_N, ENET_WR_N, ENET_RD_N;
    logic        busy, tx_done, overflow;

    dm9000a_tx_sequencer #(.DEPTH(64), .WR_PULSE(WR_PULSE), .WR_GAP(WR_GAP), .HOLDOFF(HOLDOFF)) dut (
        .CLOCK_50(clk), .RST_N(RST_N),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .ENET_DATA(ENET_DATA), .ENET_CMD(ENET_CMD), .ENET_CS_N(ENET_CS_N),
        .ENET_WR_N(ENET_WR_N), .ENET_RD_N(ENET_RD_N),
        .busy(busy), .tx_done(tx_done), .overflow(overflow)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor state
    logic [16:0] m_wr[$];
    int          m_fall[$];
    int          cur_cs, cur_wr;
    logic [16:0] cur_d;
    bit          cur_bad;
    bit          active = 0;
    logic        prev_cs = 1'b1;
    int          timing_bad, tx_cnt, tx_cyc, ovf_cnt, rdy_bad;

    always @(negedge clk) begin
        if (!ENET_CS_N && prev_cs) begin
            m_wr.push_back({ENET_CMD, ENET_DATA});
            m_fall.push_back(cyc);
            cur_d   = {ENET_CMD, ENET_DATA};
            cur_cs  = 1;
            cur_wr  = 0;
            cur_bad = !ENET_WR_N;
            active  = 1;
        end else if (!ENET_CS_N) begin
            cur_cs++;
            if (!ENET_WR_N) cur_wr++;
            if ({ENET_CMD, ENET_DATA} !== cur_d) cur_bad = 1;
        end else if (active) begin
            active = 0;
            if (cur_cs != 1 + WR_PULSE || cur_wr != WR_PULSE || cur_bad) timing_bad++;
        end
        if (!ENET_WR_N && ENET_CS_N) timing_bad++;
        if (!ENET_RD_N) timing_bad++;
        prev_cs = ENET_CS_N;
        if (tx_done) begin tx_cnt++; tx_cyc = cyc; end
        if (overflow) ovf_cnt++;
        if (busy && s_ready) rdy_bad++;
    end

    task automatic clear_mon();
        m_wr.delete();
        m_fall.delete();
        timing_bad = 0; tx_cnt = 0; tx_cyc = 0; ovf_cnt = 0; rdy_bad = 0;
    endtask

    // Present one word at a negedge and return at the negedge after it is accepted.
    task automatic push(input logic [15:0] d, input logic last);
        int t = 0;
        s_data = d; s_last = last; s_valid = 1'b1;
        while (!s_ready && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) check("push_timeout", 0, 1);
        @(negedge clk);
    endtask

    logic [15:0] fw[$];

    task automatic check_frame(input string tag);
        int n = fw.size();
        int ntot = (n < MIN_WORDS) ? MIN_WORDS : n;
        logic [15:0] len = 16'(ntot * 2);
        logic [16:0] exp[$];
        int pb = 0;
        exp.push_back({1'b0, 16'h00F8});
        for (int i = 0; i < ntot; i++) exp.push_back({1'b1, (i < n) ? fw[i] : 16'h0000});
        exp.push_back({1'b0, 16'h00FC});
        exp.push_back({1'b1, 8'h00, len[7:0]});
        exp.push_back({1'b0, 16'h00FD});
        exp.push_back({1'b1, 8'h00, len[15:8]});
        exp.push_back({1'b0, 16'h0002});
        exp.push_back({1'b1, 16'h0001});
        check({tag, "_nwr"}, m_wr.size(), exp.size());
        for (int i = 0; i < exp.size() && i < m_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 32'(m_wr[i]), 32'(exp[i]));
        for (int i = 1; i < m_fall.size(); i++)
            if (m_fall[i] - m_fall[i-1] != WR_LEN) pb++;
        check({tag, "_period"}, pb, 0);
        check({tag, "_timing"}, timing_bad, 0);
        check({tag, "_txdone_cnt"}, tx_cnt, 1);
        if (m_fall.size() > 0)
            check({tag, "_txdone_pos"}, tx_cyc - m_fall[m_fall.size()-1], WR_LEN - 1);
        $display("frame %s: %0d words, %0d bus writes, len=%04h", tag, n, m_wr.size(), len);
    endtask

    // Send fw with s_valid held high through the transmit, then check the bus trace.
    task automatic run_frame(input string tag);
        int t = 0;
        int bf;
        clear_mon();
        for (int i = 0; i < fw.size(); i++) push(fw[i], i == fw.size() - 1);
        s_data = 16'hDEAD; s_last = 1'b0;
        check({tag, "_busy_after_last"}, {busy, s_ready}, 2'b10);
        while (busy && t < 3000) begin @(negedge clk); t++; end
        bf = cyc;
        s_valid = 1'b0;
        check({tag, "_idle_timeout"}, t < 3000, 1);
        check({tag, "_ready_in_tx"}, rdy_bad, 0);
        check({tag, "_holdoff"}, bf - tx_cyc, HOLDOFF + 1);
        check({tag, "_ready_after"}, s_ready, 1);
        check({tag, "_ovf"}, ovf_cnt, 0);
        check_frame(tag);
    endtask

    initial begin
        int t;
        RST_N = 1'b0; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_data", ENET_DATA, 16'h0000);
        check("rst_cmd", ENET_CMD, 0);
        check("rst_cs_n", ENET_CS_N, 1);
        check("rst_wr_n", ENET_WR_N, 1);
        check("rst_rd_n", ENET_RD_N, 1);
        check("rst_flags", {busy, tx_done, overflow}, 3'b000);
        RST_N = 1'b1;
        @(negedge clk);
        check("ready_after_rst", s_ready, 1);

        fw = '{16'h1111, 16'h2222, 16'h3333};
        run_frame("f3");

        // 65 words into a 64-word buffer: dropped without any bus activity.
        clear_mon();
        for (int i = 0; i < 65; i++) begin
            push(16'(16'h0100 + i), i == 64);
            if (i == 62) check("ovf_early", overflow, 0);
            if (i == 63) check("ovf_at64", overflow, 1);
        end
        s_valid = 1'b0; s_last = 1'b0;
        repeat (5) @(negedge clk);
        check("ovf_count", ovf_cnt, 1);
        check("drop_no_bus", m_wr.size(), 0);
        check("drop_idle", {busy, s_ready}, 2'b01);
        $display("frame ovf: 65 words dropped, overflow pulses=%0d", ovf_cnt);

        fw = '{16'hAAAA, 16'hBBBB};
        run_frame("f2");

        // Reset while payload word 2 is being strobed.
        clear_mon();
        fw = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04};
        for (int i = 0; i < fw.size(); i++) push(fw[i], i == fw.size() - 1);
        s_valid = 1'b0; s_last = 1'b0;
        t = 0;
        while (!(ENET_CS_N == 1'b0 && ENET_WR_N == 1'b0 && ENET_DATA == 16'h0A03) && t < 500) begin
            @(negedge clk); t++;
        end
        check("abort_wait", t < 500, 1);
        RST_N = 1'b0;
        @(negedge clk);
        check("abort_cs_n", ENET_CS_N, 1);
        check("abort_wr_n", ENET_WR_N, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", s_ready, 0);
        check("abort_txdone", tx_cnt, 0);
        $display("frame abort: reset after %0d bus writes", m_wr.size());
        RST_N = 1'b1;
        repeat (2) @(negedge clk);

        fw = '{16'h55D5};
        run_frame("f1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
